// File: rtl/cpu_ctrl.sv
// Instruction sequencer for the 8-bit CPU: fetch/decode FSM, control strobe decode,
// latched ALU flags for conditional jumps, and run / single-step / halt handling.
module cpu_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       step,
    input  logic [7:0] instr,
    input  logic       f_c,
    input  logic       f_z,
    output logic [2:0] bus_src,
    output logic [3:0] operand,
    output logic       mar_load,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       a_load,
    output logic       b_load,
    output logic       ram_we,
    output logic       out_load,
    output logic       alu_en,
    output logic [1:0] alu_op,
    output logic       halted
);

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_AND = 2'b11;

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_PC   = 3'd1;
    localparam logic [2:0] BUS_RAM  = 3'd2;
    localparam logic [2:0] BUS_OPND = 3'd3;
    localparam logic [2:0] BUS_A    = 3'd4;
    localparam logic [2:0] BUS_ALU  = 3'd5;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_STA = 4'h6;
    localparam logic [3:0] OP_LDI = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JC  = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        IDLE, FETCH0, FETCH1, EX0, EX1, EX2, EX3, HALT
    } state_t;

    state_t     state_reg;
    logic [7:0] ir_reg;
    logic       flag_c_reg;
    logic       flag_z_reg;

    logic [3:0] opcode;
    logic       is_alu;
    logic       uses_mar;
    state_t     done_state;

    assign opcode     = ir_reg[7:4];
    assign is_alu     = (opcode >= OP_ADD) && (opcode <= OP_AND);
    assign uses_mar   = is_alu || (opcode == OP_LDA) || (opcode == OP_STA);
    assign done_state = run ? FETCH0 : IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            ir_reg     <= 8'h00;
            flag_c_reg <= 1'b0;
            flag_z_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE:   if (run || step) state_reg <= FETCH0;
                FETCH0: state_reg <= FETCH1;
                FETCH1: begin
                    ir_reg    <= instr;
                    state_reg <= EX0;
                end
                EX0: begin
                    if (opcode == OP_HLT)  state_reg <= HALT;
                    else if (uses_mar)     state_reg <= EX1;
                    else                   state_reg <= done_state;
                end
                EX1:    state_reg <= is_alu ? EX2 : done_state;
                EX2:    state_reg <= EX3;
                EX3: begin
                    // Flags come from the registered ALU, valid one cycle after alu_en.
                    flag_c_reg <= f_c;
                    flag_z_reg <= f_z;
                    state_reg  <= done_state;
                end
                HALT:   state_reg <= HALT;
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus_src  = BUS_NONE;
        mar_load = 1'b0;
        ir_load  = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        a_load   = 1'b0;
        b_load   = 1'b0;
        ram_we   = 1'b0;
        out_load = 1'b0;
        alu_en   = 1'b0;
        alu_op   = ALU_ADD;
        halted   = (state_reg == HALT);
        // IDLE and HALT present an all-quiet interface, operand included.
        operand  = ((state_reg == IDLE) || (state_reg == HALT)) ? 4'h0 : ir_reg[3:0];

        case (state_reg)
            FETCH0: begin
                bus_src  = BUS_PC;
                mar_load = 1'b1;
            end
            FETCH1: begin
                bus_src = BUS_RAM;
                ir_load = 1'b1;
                pc_inc  = 1'b1;
            end
            EX0: begin
                if (uses_mar) begin
                    bus_src  = BUS_OPND;
                    mar_load = 1'b1;
                end else begin
                    case (opcode)
                        OP_LDI: begin
                            bus_src = BUS_OPND;
                            a_load  = 1'b1;
                        end
                        OP_JMP: begin
                            bus_src = BUS_OPND;
                            pc_load = 1'b1;
                        end
                        OP_JC: if (flag_c_reg) begin
                            bus_src = BUS_OPND;
                            pc_load = 1'b1;
                        end
                        OP_JZ: if (flag_z_reg) begin
                            bus_src = BUS_OPND;
                            pc_load = 1'b1;
                        end
                        OP_OUT: begin
                            bus_src  = BUS_A;
                            out_load = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            EX1: begin
                if (opcode == OP_LDA) begin
                    bus_src = BUS_RAM;
                    a_load  = 1'b1;
                end else if (opcode == OP_STA) begin
                    bus_src = BUS_A;
                    ram_we  = 1'b1;
                end else if (is_alu) begin
                    bus_src = BUS_RAM;
                    b_load  = 1'b1;
                end
            end
            EX2: begin
                if (is_alu) begin
                    alu_en = 1'b1;
                    case (opcode)
                        OP_SUB:  alu_op = ALU_SUB;
                        OP_OR:   alu_op = ALU_OR;
                        OP_AND:  alu_op = ALU_AND;
                        default: alu_op = ALU_ADD;
                    endcase
                end
            end
            EX3: begin
                if (is_alu) begin
                    bus_src = BUS_ALU;
                    a_load  = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
